// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit in front of a word-only DMEM.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/HU/W instead of aligning down.
module dmem_lsu #(
  parameter logic [31:0] DMEM_BASE  = 32'h8000_0000,
  parameter int          DMEM_BYTES = 1024,
  parameter int          READ_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, RD_WAIT, WRITE, RESP
  } state_t;

  localparam logic [31:0] DMEM_END =
    DMEM_BASE + 32'(DMEM_BYTES);
  localparam logic [2:0] CNT_LAST = 3'(READ_LAT - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;

  logic        hs, in_range, illegal, misalign;
  logic        is_b, is_h, is_w;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val, merge_val;

  assign req_ready  = rst_n && (state_q == IDLE);
  assign hs         = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign mem_read   = (state_q == RD_WAIT);
  assign mem_write  = (state_q == WRITE);
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign in_range = (req_addr >= DMEM_BASE) &&
                    (req_addr < DMEM_END);

  // Loads may be signed or unsigned; stores are B/H/W only.
  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b1;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign =
    (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign is_b = (f3_q[1:0] == 2'b00);
  assign is_h = (f3_q[1:0] == 2'b01);
  assign is_w = (f3_q[1:0] == 2'b10);

  assign lane_byte = mem_rdata[{lane_q, 3'b000} +: 8];
  assign lane_half = lane_q[1] ? mem_rdata[31:16]
                               : mem_rdata[15:0];

  // Lane select and extension of the returned word.
  always_comb begin
    load_val = mem_rdata;
    unique case (1'b1)
      is_w: load_val = mem_rdata;
      is_h: load_val = {{16{lane_half[15] & ~f3_q[2]}},
                        lane_half};
      is_b: load_val = {{24{lane_byte[7] & ~f3_q[2]}},
                        lane_byte};
      default: load_val = mem_rdata;
    endcase
  end

  // Replace the addressed lane(s), keep the rest of the word.
  always_comb begin
    merge_val = mem_rdata;
    if (is_h)
      merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else
      merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          maddr_d  = {req_addr[31:2], 2'b00};
          mwdata_d = req_wdata;
          cnt_d    = 3'd0;
          if (illegal || misalign) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (!in_range) begin
            rdata_d = 32'd0;
            err_d   = 1'b0;
            state_d = RESP;
          end else if (req_we &&
                       req_funct3[1:0] == 2'b10) begin
            state_d = WRITE;
          end else begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = 3'd0;
          if (we_q) begin
            mwdata_d = merge_val;
            state_d  = WRITE;
          end else begin
            rdata_d = load_val;
            err_d   = 1'b0;
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  // Request fields captured on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      wdata_q <= 16'd0;
    end else if (hs) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata[15:0];
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed + random checks of dmem_lsu
// against a byte-array reference model.
module tb_dmem_lsu;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          BYTES = 1024;
  localparam int          RL    = 1;
  localparam int          WORDS = BYTES / 4;
  localparam int          AW    = $clog2(WORDS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int both_hi = 0;

  logic [31:0] dmem [WORDS] = '{default: 32'h0};
  logic [7:0]  refm [BYTES] = '{default: 8'h0};

  dmem_lsu #(
    .DMEM_BASE (BASE),
    .DMEM_BYTES(BYTES),
    .READ_LAT  (RL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[AW+1:2]];

  always @(posedge clk)
    if (mem_write) dmem[mem_addr[AW+1:2]] <= mem_wdata;

  always @(negedge clk)
    if (mem_read && mem_write) both_hi <= both_hi + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {refm[4*w+3], refm[4*w+2],
            refm[4*w+1], refm[4*w]};
  endfunction

  task automatic model(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        err,
    output int          lat,
    output int          nrd,
    output int          nwr,
    output logic [31:0] wa,
    output logic [31:0] wdat);
    int size, off, a;
    logic legal, sgn, mis;
    logic [31:0] v;
    rd = 0; err = 0; lat = 1; nrd = 0; nwr = 0;
    wa = 0; wdat = 0;
    size = (f3[1:0] == 2'b00) ? 1 :
           (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) ||
            (!we && (f3 == 3'd4 || f3 == 3'd5));
    sgn = !f3[2];
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (addr % size) != 0;
`endif
    if (!legal || mis) begin
      err = 1'b1;
    end else if (addr >= BASE &&
                 addr < BASE + BYTES) begin
      off = int'(addr - BASE);
      a = off - off % size;
      if (!we) begin
        v = 0;
        for (int i = 0; i < size; i++)
          v |= 32'(refm[a+i]) << (8 * i);
        if (sgn && size < 4 && v[8*size-1])
          v |= ~32'h0 << (8 * size);
        rd = v;
        lat = RL + 1;
        nrd = RL;
      end else begin
        for (int i = 0; i < size; i++)
          refm[a+i] = wd[8*i +: 8];
        nwr = 1;
        wa = BASE + 32'(off - off % 4);
        wdat = ref_word(off / 4);
        lat = (size == 4) ? 2 : RL + 2;
        nrd = (size == 4) ? 0 : RL;
      end
    end
  endtask

  task automatic do_req(input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        output logic [31:0] rd);
    logic [31:0] e_rd, e_wa, e_wd, wa, wdv;
    logic e_err;
    int e_lat, e_nrd, e_nwr, lat, nrd, nwr, n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready", 32'(req_ready), 32'd1);
    model(we, f3, addr, wd, e_rd, e_err, e_lat,
          e_nrd, e_nwr, e_wa, e_wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; wa = 0; wdv = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++; wa = mem_addr; wdv = mem_wdata;
      end
    end while (!resp_valid && lat < 20);
    rd = resp_rdata;
    chk("latency", 32'(lat), 32'(e_lat));
    chk("rdata", resp_rdata, e_rd);
    chk("err", 32'(resp_err), 32'(e_err));
    chk("rd_cycles", 32'(nrd), 32'(e_nrd));
    chk("wr_cycles", 32'(nwr), 32'(e_nwr));
    if (e_nwr == 1) begin
      chk("waddr", wa, e_wa);
      chk("wdata", wdv, e_wd);
    end
    @(negedge clk);
    chk("resp_pulse", 32'(resp_valid), 32'd0);
    chk("resp_hold", resp_rdata, e_rd);
    chk("err_hold", 32'(resp_err), 32'(e_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0] lf [5];
    logic [2:0] f3;
    logic [31:0] addr;
    int r;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'b010, 32'h8000_000C, 32'h1234_5678, rd);
    chk("tp1_word", dmem[3], 32'h1234_5678);
    do_req(1'b0, 3'b000, 32'h8000_000E, 32'h0, rd);
    chk("tp2_lb", rd, 32'h0000_0034);
    do_req(1'b0, 3'b101, 32'h8000_000E, 32'h0, rd);
    chk("tp2_lhu", rd, 32'h0000_1234);
    do_req(1'b0, 3'b100, 32'h8000_000C, 32'h0, rd);
    chk("tp2_lbu", rd, 32'h0000_0078);

    do_req(1'b1, 3'b010, 32'h8000_0010, 32'hAABB_CCDD, rd);
    do_req(1'b1, 3'b001, 32'h8000_0012, 32'h0000_9988, rd);
    chk("tp3_word", dmem[4], 32'h9988_CCDD);
    do_req(1'b0, 3'b001, 32'h8000_0012, 32'h0, rd);
    chk("tp3_lh", rd, 32'hFFFF_9988);
    do_req(1'b0, 3'b000, 32'h8000_0011, 32'h0, rd);
    chk("tp3_lb", rd, 32'hFFFF_FFCC);

    do_req(1'b0, 3'b010, 32'h0000_000C, 32'h0, rd);
    chk("tp4_oor_lw", rd, 32'h0);
    do_req(1'b1, 3'b010, 32'h0000_000C, 32'hDEAD_BEEF, rd);

    do_req(1'b0, 3'b011, 32'h8000_0010, 32'h0, rd);
    chk("tp5_illegal_err", 32'(resp_err), 32'd1);
    do_req(1'b0, 3'b010, 32'h8000_0012, 32'h0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("tp5_mis_err", 32'(resp_err), 32'd1);
`else
    chk("tp5_lw_aligned", rd, 32'h9988_CCDD);
`endif

    do_req(1'b1, 3'b010, 32'h8000_0014, 32'h5566_7788, rd);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h8000_0014; req_wdata = 32'h0000_00EE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("tp6_in_rdwait", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("tp6_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("tp6_valid", 32'(resp_valid), 32'd0);
    chk("tp6_ready_low", 32'(req_ready), 32'd0);
    chk("tp6_maddr", mem_addr, 32'd0);
    chk("tp6_wdata", mem_wdata, 32'd0);
    chk("tp6_rdata", resp_rdata, 32'd0);
    chk("tp6_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tp6_ready", 32'(req_ready), 32'd1);
    chk("tp6_word", dmem[5], 32'h5566_7788);
    do_req(1'b0, 3'b010, 32'h8000_0014, 32'h0, rd);

    do_req(1'b1, 3'b010, BASE + BYTES - 4, 32'hCAFE_F00D, rd);
    do_req(1'b0, 3'b010, BASE + BYTES - 4, 32'h0, rd);
    chk("last_word", rd, 32'hCAFE_F00D);
    do_req(1'b1, 3'b010, BASE + BYTES, 32'h1111_1111, rd);
    do_req(1'b0, 3'b000, BASE - 1, 32'h0, rd);

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 7);
      addr = (r == 0) ? $urandom :
             (r == 1) ? BASE + BYTES - 4 + $urandom_range(0, 7) :
             (r == 2) ? BASE - 1 - $urandom_range(0, 3) :
                        BASE + $urandom_range(0, 63);
      f3 = ($urandom_range(0, 4) == 0) ?
           3'($urandom_range(0, 7)) : lf[$urandom_range(0, 4)];
      do_req(1'($urandom_range(0, 1)), f3, addr,
             $urandom, rd);
    end

    for (int w = 0; w < WORDS; w++)
      chk("final_mem", dmem[w], ref_word(w));
    chk("read_write_overlap", 32'(both_hi), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of DMEM in the MEM stage.
- Accepts one load/store request from the pipeline and decodes its address against the DMEM window.
- Sub-word stores are done as read-modify-write, because DMEM writes full words only.
- Load data is returned after lane selection and sign/zero extension per funct3. Multi-cycle; handshakes with the pipeline via valid/ready.

Parameters:
- DMEM_BASE, 32'h8000_0000, byte base address of the DMEM window.
- DMEM_BYTES, 1024, window size in bytes (power of 2, ≥4).
- READ_LAT, 1, cycles from mem_read/mem_addr asserted to mem_rdata valid (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept (high only in IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result (0 for stores).
- resp_err  out  1  error on this response.
- mem_read  out  1  DMEM read enable.
- mem_write  out  1  DMEM write enable (one cycle).
- mem_addr  out  32  word-aligned address to DMEM (low 2 bits 0).
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  DMEM read data.

Behaviour:
Reset (async, rst_n=0): state=IDLE, req_ready=0 while rst_n low then 1, resp_valid=0, resp_rdata=0, resp_err=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, wait counter=0.

Request capture:
- Handshake on clk edge with req_valid && req_ready. funct3/addr/wdata/we are latched.
- req_ready drops the next cycle.

Decode:
- In range iff DMEM_BASE ≤ addr < DMEM_BASE+DMEM_BYTES. mem_addr = {addr[31:2],2'b00}.
- Lane = addr[1:0], little-endian. Byte lane k = bits[8k+7:8k]; halfword uses addr[1] (bits[15:0] or [31:16]).

States:
- IDLE: wait for handshake. Next state:
  - illegal funct3 (011, 110, 111, or 100/101 with we=1) → RESP with err=1.
  - out-of-range → RESP, rdata=0, err=0, no mem strobes.
  - SW → WRITE.
  - any load, SB, or SH → RD_WAIT.
- RD_WAIT: mem_read=1 held. Counter counts READ_LAT cycles, then mem_rdata is sampled.
  - load → RESP with extracted data: B/H sign-extend, BU/HU zero-extend, W as-is.
  - SB/SH → WRITE with merged word (selected lane(s) replaced by req_wdata[7:0]/[15:0], other bytes preserved).
- WRITE: mem_write=1 for exactly one cycle with mem_wdata; → RESP.
- RESP: resp_valid=1 one cycle, then IDLE; req_ready=1 in following cycle (no back-to-back acceptance in RESP).

Latency:
- handshake→resp_valid: SW = 2 cycles; load = READ_LAT+1; SB/SH = READ_LAT+2; out-of-range/illegal = 1.

Other rules:
- mem_read and mem_write are never high in the same cycle.
- resp_rdata/resp_err hold their value until the next RESP.
- Without the macro, misaligned addresses are aligned down by size (H ignores addr[0]; W ignores addr[1:0]).
- Reset mid-operation: the FSM aborts to IDLE immediately. A pending RMW write is never issued; DMEM is unchanged.
- req_valid with req_ready=0 is ignored; the pipeline must hold it.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: H/HU with addr[0]=1, or W with addr[1:0]≠0, → RESP with err=1, rdata=0, no DMEM access, latency 1.
- Undefined: aligned-down behaviour as above; err never set for alignment.

Test Plan:
1. SW addr 0x8000_000C data 0x1234_5678 → one mem_write cycle, mem_addr 0x8000_000C, mem_wdata 0x1234_5678, resp_valid 2 cycles after handshake, err=0.
2. After 1, LB addr 0x8000_000E → mem_read for READ_LAT cycles, resp_rdata 0x0000_0034. LHU 0x8000_000E → 0x0000_1234. LBU 0x8000_000C → 0x0000_0078.
3. Word 0x8000_0010 preloaded 0xAABB_CCDD; SH 0x8000_0012 data 0x0000_9988 → write 0x9988_CCDD. LH → 0xFFFF_9988. LB 0x8000_0011 → 0xFFFF_FFCC.
4. LW addr 0x0000_000C (out of range) → resp_rdata 0, err 0, mem_read/mem_write never asserted. SW there → no mem_write.
5. funct3=011 → err=1 after 1 cycle, no strobes. LW 0x8000_0012: with macro → err=1, no strobes; without macro → reads word 0x8000_0010.
6. rst_n pulsed low during RD_WAIT of SB 0x8000_0014 → outputs reset immediately, no mem_write, word unchanged, req_ready=1 after release.
